// File: rtl/sec32_encoder.sv
// sec32_encoder: two-stage pipelined encoder producing the 8 check bits of the
// team's 32-bit single-error-correcting code.
// Stage S1 captures the data word together with 8 nibble parities and 8 column
// parities. Stage S2 combines those partials into the check byte and presents
// the codeword. Both stages use a valid/ready handshake with full throughput.
// Optional feature macro: SEC32_ENC_ERRINJ_EN adds inj_en/inj_pos ports, which
// flip one codeword bit (data bits 0..31, check bits 32..39) for fault testing.
module sec32_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_check,
  output logic [15:0] word_cnt
`ifdef SEC32_ENC_ERRINJ_EN
  ,
  input  logic        inj_en,
  input  logic [5:0]  inj_pos
`endif
);

  // Parity of each 4-bit nibble: bit i covers d[4i+3:4i].
  function automatic logic [7:0] nibble_parity(input logic [31:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) begin
      p[i] = ^d[4*i +: 4];
    end
    return p;
  endfunction

  // Column parities: bits 0..3 fold the low half by bit-within-nibble,
  // bits 4..7 fold the high half the same way.
  function automatic logic [7:0] column_parity(input logic [31:0] d);
    logic [7:0] p;
    for (int k = 0; k < 4; k++) begin
      p[k]     = d[k]      ^ d[k + 4]  ^ d[k + 8]  ^ d[k + 12];
      p[k + 4] = d[k + 16] ^ d[k + 20] ^ d[k + 24] ^ d[k + 28];
    end
    return p;
  endfunction

  // Combine partial parities into the check byte expected by the corrector.
  function automatic logic [7:0] check_from_partials(input logic [7:0] n,
                                                     input logic [7:0] c);
    logic [7:0] r;
    r[0] = n[4] ^ n[5] ^ c[0];
    r[1] = n[6] ^ n[7] ^ c[1];
    r[2] = n[4] ^ n[6] ^ c[2];
    r[3] = n[5] ^ n[7] ^ c[3];
    r[4] = n[0] ^ n[1] ^ c[4];
    r[5] = n[2] ^ n[3] ^ c[5];
    r[6] = n[0] ^ n[2] ^ c[6];
    r[7] = n[1] ^ n[3] ^ c[7];
    return r;
  endfunction

  logic        s1_valid_r;
  logic [31:0] s1_data_r;
  logic [7:0]  s1_nib_r;
  logic [7:0]  s1_col_r;
  logic        s2_adv_s;
  logic        in_ready_s;
  logic        accept_s;
  logic [39:0] code_s;
`ifdef SEC32_ENC_ERRINJ_EN
  logic        s1_inj_en_r;
  logic [5:0]  s1_inj_pos_r;
  logic [39:0] flip_s;
`endif

  // S2 can take a new word when it is empty or its word leaves this cycle;
  // S1 is free under the same condition since it then drains into S2.
  assign s2_adv_s   = !out_valid || out_ready;
  assign in_ready_s = !s1_valid_r || s2_adv_s;
  assign accept_s   = in_valid && in_ready_s;
  assign in_ready   = in_ready_s;

`ifdef SEC32_ENC_ERRINJ_EN
  // Build the one-hot flip mask; positions 40..63 fall outside the codeword.
  always_comb begin
    flip_s = 40'd0;
    if (s1_inj_en_r && (s1_inj_pos_r < 6'd40)) begin
      flip_s = 40'd1 << s1_inj_pos_r;
    end else begin
      flip_s = 40'd0;
    end
  end
`endif

  // Assemble the S2 codeword {check, data} from the S1 partial parities.
  always_comb begin
    code_s = {check_from_partials(s1_nib_r, s1_col_r), s1_data_r};
`ifdef SEC32_ENC_ERRINJ_EN
    code_s = code_s ^ flip_s;
`endif
  end

  // S1: capture the accepted word and its partial parities.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_data_r    <= 32'd0;
      s1_nib_r     <= 8'd0;
      s1_col_r     <= 8'd0;
`ifdef SEC32_ENC_ERRINJ_EN
      s1_inj_en_r  <= 1'b0;
      s1_inj_pos_r <= 6'd0;
`endif
    end else begin
      if (in_ready_s) begin
        s1_valid_r <= in_valid;
      end
      if (accept_s) begin
        s1_data_r    <= in_data;
        s1_nib_r     <= nibble_parity(in_data);
        s1_col_r     <= column_parity(in_data);
`ifdef SEC32_ENC_ERRINJ_EN
        s1_inj_en_r  <= inj_en;
        s1_inj_pos_r <= inj_pos;
`endif
      end
    end
  end

  // S2: present the codeword; hold it while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_check <= 8'd0;
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data  <= code_s[31:0];
        out_check <= code_s[39:32];
      end
    end
  end

  // Count emitted words, sticking at the maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= 16'd0;
    end else if (out_valid && out_ready && (word_cnt != 16'hFFFF)) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sec32_encoder.sv
// tb_sec32_encoder: directed self-checking bench for sec32_encoder.
module tb_sec32_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic [15:0] word_cnt;
`ifdef SEC32_ENC_ERRINJ_EN
  logic        inj_en;
  logic [5:0]  inj_pos;
`endif

  int n_assert;
  int n_fail;
  int exp_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] got_d;
  logic [7:0]  got_c;

  sec32_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_check (out_check),
    .word_cnt  (word_cnt)
`ifdef SEC32_ENC_ERRINJ_EN
    ,
    .inj_en    (inj_en),
    .inj_pos   (inj_pos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference check bits straight from the per-bit coverage lists.
  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [31:0] m [8];
    logic [7:0]  r;
    m[0] = 32'h00FF1111;
    m[1] = 32'hFF002222;
    m[2] = 32'h0F0F4444;
    m[3] = 32'hF0F08888;
    m[4] = 32'h111100FF;
    m[5] = 32'h2222FF00;
    m[6] = 32'h44440F0F;
    m[7] = 32'h8888F0F0;
    for (int j = 0; j < 8; j++) r[j] = ^(d & m[j]);
    return r;
  endfunction

  // Corrector: zero syndrome passes through, data-bit syndrome flips that bit.
  function automatic logic [31:0] correct(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  syn;
    logic [31:0] one;
    logic [31:0] res;
    syn = ref_check(d) ^ c;
    res = d;
    for (int k = 0; k < 32; k++) begin
      one = 32'd1 << k;
      if (syn != 8'd0 && ref_check(one) == syn) res = d ^ one;
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one word with the sink ready; check 2-cycle latency and content.
  task automatic send_vec(input string tag, input logic [31:0] d,
                          input logic [31:0] ed, input logic [7:0] ec,
                          output logic [31:0] od, output logic [7:0] oc);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
`ifdef SEC32_ENC_ERRINJ_EN
    inj_en  = 1'b0;
    inj_pos = 6'd0;
`endif
    chk({tag, "_valid_c1"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid_c2"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_check"}, out_check, ec);
    od = out_data;
    oc = out_check;
    tick();
    exp_cnt++;
    chk({tag, "_valid_after"}, out_valid, 1'b0);
    chk({tag, "_cnt"}, word_cnt, exp_cnt);
  endtask

  // Compare a presented output word against the in-order expectation queue.
  task automatic check_out(input string tag);
    logic [31:0] e;
    if (out_valid) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_data"}, out_data, e);
        chk({tag, "_syndrome"}, ref_check(out_data) ^ out_check, 8'd0);
        if (out_ready) exp_cnt++;
      end else begin
        chk({tag, "_extra_word"}, out_data, 32'hFFFFFFFF ^ out_data);
      end
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    exp_cnt   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
`ifdef SEC32_ENC_ERRINJ_EN
    inj_en  = 1'b0;
    inj_pos = 6'd0;
`endif

    // Reset state.
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_check", out_check, 8'd0);
    chk("rst_word_cnt", word_cnt, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed vectors with hand-computed check bytes.
    send_vec("v_zero", 32'h00000000, 32'h00000000, 8'h00, got_d, got_c);
    send_vec("v_one", 32'h00000001, 32'h00000001, 8'h51, got_d, got_c);
    send_vec("v_msb", 32'h80000000, 32'h80000000, 8'h8A, got_d, got_c);
    send_vec("v_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, got_d, got_c);
    send_vec("v_b16", 32'h00010000, 32'h00010000, 8'h15, got_d, got_c);

    // Backpressure: three words offered with the sink stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00000001;
    tick();
    in_data = 32'h80000000;
    #1;
    chk("stall_ready_1", in_ready, 1'b1);
    tick();
    in_data = 32'h00010000;
    #1;
    chk("stall_ready_fall", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold_valid", out_valid, 1'b1);
      chk("stall_hold_data", out_data, 32'h00000001);
      chk("stall_hold_check", out_check, 8'h51);
      chk("stall_hold_cnt", word_cnt, exp_cnt);
      tick();
      chk("stall_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    chk("stall_out_b", out_data, 32'h80000000);
    chk("stall_chk_b", out_check, 8'h8A);
    tick();
    exp_cnt++;
    chk("stall_out_c", out_data, 32'h00010000);
    chk("stall_chk_c", out_check, 8'h15);
    chk("stall_valid_c", out_valid, 1'b1);
    tick();
    exp_cnt++;
    chk("stall_drained", out_valid, 1'b0);
    chk("stall_cnt", word_cnt, exp_cnt);

    // Reset with two words in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h12345678;
    tick();
    in_data = 32'hCAFEF00D;
    tick();
    in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_word_cnt", word_cnt, 16'd0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_data", out_data, 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale_word", out_valid, 1'b0);
    end

    // 100 random words back-to-back.
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      exp_q.push_back(in_data);
      tick();
      check_out("burst");
    end
    in_valid = 1'b0;
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
      tick();
      check_out("burst");
    end
    chk("burst_queue_empty", exp_q.size(), 0);
    tick();
    chk("burst_valid_end", out_valid, 1'b0);
    chk("burst_word_cnt", word_cnt, 16'd100);

`ifdef SEC32_ENC_ERRINJ_EN
    // Error injection, sampled with the word at acceptance.
    inj_en  = 1'b1;
    inj_pos = 6'd5;
    send_vec("inj5", 32'h0, 32'h00000020, 8'h00, got_d, got_c);
    chk("inj5_corrected", correct(got_d, got_c), 32'h0);
    inj_en  = 1'b1;
    inj_pos = 6'd33;
    send_vec("inj33", 32'h0, 32'h00000000, 8'h02, got_d, got_c);
    inj_en  = 1'b1;
    inj_pos = 6'd45;
    send_vec("inj45", 32'h0, 32'h00000000, 8'h00, got_d, got_c);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
